// File: rtl/player_motion_controller_if.sv
// Bundles the per-frame control inputs and player status outputs of the
// player motion controller so producer and consumer share one port.
interface player_motion_controller_if;
  logic       frame_tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [9:0] PlayerX;
  logic [9:0] PlayerY;
  logic       moving;
  logic       playerDirection;
  logic       airborne;
  logic [1:0] jump_state;

  // Keyboard/frame side: drives the requests, observes the player status.
  modport master (
    output frame_tick, key_left, key_right, key_jump,
    input  PlayerX, PlayerY, moving, playerDirection, airborne, jump_state
  );

  // Controller side: consumes the requests, produces the player status.
  modport slave (
    input  frame_tick, key_left, key_right, key_jump,
    output PlayerX, PlayerY, moving, playerDirection, airborne, jump_state
  );
endinterface

// File: rtl/player_motion_controller.sv
// Converts keyboard intent into player position, facing and motion status
// once per video frame: clamped horizontal walking plus a
// grounded/rising/falling jump machine with constant gravity.
module player_motion_controller #(
  parameter logic [9:0] START_X   = 10'd50,
  parameter logic [9:0] GROUND_Y  = 10'd380,
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] X_MAX     = 10'd596,
  parameter logic [9:0] WALK_STEP = 10'd2,
  parameter logic [5:0] JUMP_VEL  = 6'd12,
  parameter logic [5:0] GRAVITY   = 6'd1,
  parameter logic [5:0] MAX_FALL  = 6'd12
) (
  input logic                        frame_Clk,
  input logic                        Reset,
  player_motion_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    GROUNDED = 2'b00,
    RISING   = 2'b01,
    FALLING  = 2'b10
  } jumpState_t;

  jumpState_t r_state;
  logic [5:0] r_vy;
  logic [9:0] r_playerX;
  logic [9:0] r_playerY;
  logic       r_direction;
  logic       r_moving;
  logic       r_airborne;
  logic       r_jumpPrev;

  jumpState_t        w_stateNext;
  logic [5:0]        w_vyNext;
  logic [9:0]        w_xNext;
  logic [9:0]        w_yNext;
  logic              w_dirNext;
  logic              w_movingNext;
  logic              w_jumpEdge;
  logic              w_walkLeft;
  logic              w_walkRight;
  logic [10:0]       w_xWide;
  logic [10:0]       w_leftLimit;
  logic [10:0]       w_xPlus;
  logic signed [10:0] w_yUp;
  logic [10:0]       w_yDown;
  logic [5:0]        w_vyDec;
  logic [6:0]        w_vnSum;
  logic [5:0]        w_vn;

  assign w_jumpEdge  = bus.key_jump & ~r_jumpPrev;
  assign w_walkLeft  = bus.key_left & ~bus.key_right;
  assign w_walkRight = bus.key_right & ~bus.key_left;

  // Widened arithmetic so neither clamping nor vertical motion can wrap.
  assign w_xWide     = {1'b0, r_playerX};
  assign w_leftLimit = {1'b0, X_MIN} + {1'b0, WALK_STEP};
  assign w_xPlus     = w_xWide + {1'b0, WALK_STEP};
  assign w_yUp       = $signed({1'b0, r_playerY}) - $signed({5'b0, r_vy});
  assign w_vyDec     = r_vy - GRAVITY;
  assign w_vnSum     = {1'b0, r_vy} + {1'b0, GRAVITY};
  assign w_vn        = (w_vnSum > {1'b0, MAX_FALL}) ? MAX_FALL : w_vnSum[5:0];
  assign w_yDown     = {1'b0, r_playerY} + {5'b0, w_vn};

  // Next-state logic: jump machine, clamped walking and the moving flag.
  always_comb begin
    w_stateNext  = r_state;
    w_vyNext     = r_vy;
    w_yNext      = r_playerY;
    w_xNext      = r_playerX;
    w_dirNext    = r_direction;
    w_movingNext = 1'b0;

    case (r_state)
      GROUNDED: begin
        if (w_jumpEdge) begin
          w_stateNext = RISING;
          w_vyNext    = JUMP_VEL;
        end else begin
          w_yNext = GROUND_Y;
        end
      end
      RISING: begin
        if (w_yUp < 0) begin
          w_yNext     = 10'd0;
          w_vyNext    = 6'd0;
          w_stateNext = FALLING;
        end else begin
          w_yNext = w_yUp[9:0];
          if (w_vyDec == 6'd0) begin
            w_vyNext    = 6'd0;
            w_stateNext = FALLING;
          end else begin
            w_vyNext = w_vyDec;
          end
        end
      end
      FALLING: begin
        if (w_yDown >= {1'b0, GROUND_Y}) begin
          w_yNext     = GROUND_Y;
          w_vyNext    = 6'd0;
          w_stateNext = GROUNDED;
        end else begin
          w_yNext  = w_yDown[9:0];
          w_vyNext = w_vn;
        end
      end
      default: begin
        w_stateNext = GROUNDED;
        w_vyNext    = 6'd0;
        w_yNext     = GROUND_Y;
      end
    endcase

    if (w_walkLeft) begin
      w_dirNext = 1'b1;
      w_xNext   = (w_xWide < w_leftLimit) ? X_MIN : (r_playerX - WALK_STEP);
    end else if (w_walkRight) begin
      w_dirNext = 1'b0;
      w_xNext   = (w_xPlus > {1'b0, X_MAX}) ? X_MAX : w_xPlus[9:0];
    end

    w_movingNext = (w_walkLeft | w_walkRight) & (w_stateNext == GROUNDED);
  end

  // State and output registers advance once per frame tick; reset wins.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      r_state     <= GROUNDED;
      r_vy        <= 6'd0;
      r_playerX   <= START_X;
      r_playerY   <= GROUND_Y;
      r_direction <= 1'b0;
      r_moving    <= 1'b0;
      r_airborne  <= 1'b0;
      r_jumpPrev  <= 1'b0;
    end else if (bus.frame_tick) begin
      r_state     <= w_stateNext;
      r_vy        <= w_vyNext;
      r_playerX   <= w_xNext;
      r_playerY   <= w_yNext;
      r_direction <= w_dirNext;
      r_moving    <= w_movingNext;
      r_airborne  <= (w_stateNext != GROUNDED);
      r_jumpPrev  <= bus.key_jump;
    end
  end

  assign bus.PlayerX         = r_playerX;
  assign bus.PlayerY         = r_playerY;
  assign bus.moving          = r_moving;
  assign bus.playerDirection = r_direction;
  assign bus.airborne        = r_airborne;
  assign bus.jump_state      = r_state;

endmodule

// File: tb/tb_player_motion_controller.sv
// Self-checking bench for player_motion_controller: directed scenarios
// followed by randomized key activity, all compared against a behavioural
// model of walking, jumping and gravity.
module tb_player_motion_controller;

  logic frame_Clk = 1'b0;
  logic Reset     = 1'b1;

  player_motion_controller_if bus();

  player_motion_controller dut (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  // 100 MHz-style free-running clock.
  always #5 frame_Clk = ~frame_Clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: plain integers, 0/1/2 for grounded/rising/falling.
  int mX, mY, mVy, mState, mDir, mMoving, mAir, mPrev;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mX = 50; mY = 380; mVy = 0; mState = 0;
    mDir = 0; mMoving = 0; mAir = 0; mPrev = 0;
  endtask

  // One frame of the physics rules, written directly from the player's view.
  task automatic modelTick(input bit l, input bit r, input bit j);
    bit edgeSeen;
    bit walking;
    int vn;
    edgeSeen = j && !mPrev;
    mPrev    = j;
    walking  = (l != r);
    if (walking && l) begin
      mDir = 1;
      mX   = (mX - 2 < 0) ? 0 : mX - 2;
    end else if (walking && r) begin
      mDir = 0;
      mX   = (mX + 2 > 596) ? 596 : mX + 2;
    end
    if (mState == 0) begin
      if (edgeSeen) begin
        mState = 1;
        mVy    = 12;
      end else begin
        mY = 380;
      end
    end else if (mState == 1) begin
      if (mY - mVy < 0) begin
        mY = 0; mVy = 0; mState = 2;
      end else begin
        mY  = mY - mVy;
        mVy = mVy - 1;
        if (mVy == 0) mState = 2;
      end
    end else begin
      vn = (mVy + 1 > 12) ? 12 : mVy + 1;
      if (mY + vn >= 380) begin
        mY = 380; mVy = 0; mState = 0;
      end else begin
        mY = mY + vn; mVy = vn;
      end
    end
    mMoving = (walking && mState == 0) ? 1 : 0;
    mAir    = (mState != 0) ? 1 : 0;
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, " PlayerX"},  int'(bus.PlayerX),         mX);
    checkOutput({where, " PlayerY"},  int'(bus.PlayerY),         mY);
    checkOutput({where, " moving"},   int'(bus.moving),          mMoving);
    checkOutput({where, " dir"},      int'(bus.playerDirection), mDir);
    checkOutput({where, " airborne"}, int'(bus.airborne),        mAir);
    checkOutput({where, " state"},    int'(bus.jump_state),      mState);
  endtask

  // Drive one frame tick with the given keys, then compare against the model.
  task automatic applyStimulus(input bit l, input bit r, input bit j);
    bus.key_left   = l;
    bus.key_right  = r;
    bus.key_jump   = j;
    bus.frame_tick = 1'b1;
    @(posedge frame_Clk);
    #1;
    bus.frame_tick = 1'b0;
    modelTick(l, r, j);
    checkAll("tick");
  endtask

  // Synchronous reset for a number of edges with random keys and tick.
  task automatic applyReset(input int cycles);
    Reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      bus.key_left   = 1'($urandom_range(0, 1));
      bus.key_right  = 1'($urandom_range(0, 1));
      bus.key_jump   = 1'($urandom_range(0, 1));
      @(posedge frame_Clk);
      #1;
    end
    Reset          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.key_left   = 1'b0;
    bus.key_right  = 1'b0;
    bus.key_jump   = 1'b0;
    modelReset();
    checkAll("reset");
  endtask

  // Clock edges without frame_tick: keys wiggle but nothing may change.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.key_left  = 1'($urandom_range(0, 1));
      bus.key_right = 1'($urandom_range(0, 1));
      bus.key_jump  = 1'($urandom_range(0, 1));
      @(posedge frame_Clk);
      #1;
      checkAll("idle");
    end
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump  = 1'b0;
  endtask

  int airCount;
  int jumpStarts;
  int prevState;
  bit kl, kr, kj;

  initial begin
    bus.frame_tick = 1'b0;
    bus.key_left   = 1'b0;
    bus.key_right  = 1'b0;
    bus.key_jump   = 1'b0;
    modelReset();

    // Power-on reset, then confirm the spawn point.
    applyReset(3);
    checkOutput("spawn X", int'(bus.PlayerX), 50);
    checkOutput("spawn Y", int'(bus.PlayerY), 380);

    // Walk right for ten ticks, then hold through idle clocks.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("walk right X", int'(bus.PlayerX), 70);
    checkOutput("walk right moving", int'(bus.moving), 1);
    idleCycles(50);

    // Walk left into the left clamp.
    applyReset(1);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 24) checkOutput("left before clamp X", int'(bus.PlayerX), 2);
      if (i == 25) checkOutput("left clamp X", int'(bus.PlayerX), 0);
    end
    checkOutput("left clamp held X", int'(bus.PlayerX), 0);
    checkOutput("left clamp moving", int'(bus.moving), 1);
    checkOutput("left clamp dir", int'(bus.playerDirection), 1);

    // Walk right into the right clamp.
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("right clamp X", int'(bus.PlayerX), 596);

    // Single jump pulse: apex, landing tick and airborne duration.
    applyReset(1);
    airCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    if (bus.airborne) airCount++;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (bus.airborne) airCount++;
      if (i == 1)  checkOutput("jump first Y", int'(bus.PlayerY), 368);
      if (i == 12) checkOutput("jump apex Y", int'(bus.PlayerY), 302);
      if (i == 12) checkOutput("jump apex state", int'(bus.jump_state), 2);
      if (i == 23) checkOutput("pre-land state", int'(bus.jump_state), 2);
      if (i == 24) checkOutput("land Y", int'(bus.PlayerY), 380);
      if (i == 24) checkOutput("land state", int'(bus.jump_state), 0);
    end
    checkOutput("airborne ticks", airCount, 24);

    // Held key plus re-press during the rise: exactly one jump.
    applyReset(1);
    jumpStarts = 0;
    prevState  = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, (i == 3) ? 1'b0 : 1'b1);
      if (prevState == 0 && bus.jump_state == 2'b01) jumpStarts++;
      prevState = int'(bus.jump_state);
    end
    checkOutput("single jump count", jumpStarts, 1);
    checkOutput("held key grounded", int'(bus.jump_state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("re-press jumps", int'(bus.jump_state), 1);

    // Reset mid-jump snaps back to spawn.
    applyReset(1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("mid-jump Y", int'(bus.PlayerY), 323);
    applyReset(1);
    checkOutput("mid-jump reset Y", int'(bus.PlayerY), 380);
    checkOutput("mid-jump reset X", int'(bus.PlayerX), 50);
    checkOutput("mid-jump reset state", int'(bus.jump_state), 0);

    // Randomized play against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        applyReset(int'($urandom_range(1, 2)));
      end else if ($urandom_range(0, 9) == 0) begin
        idleCycles(int'($urandom_range(1, 4)));
      end else begin
        kl = ($urandom_range(0, 2) == 0);
        kr = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) kj = ~kj;
        applyStimulus(kl, kr, kj);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
